// File: rtl/mont_pkg.sv
// Shared types and encodings for the Montgomery sequencer and its chunk counter.
// Combinational constants only; no latency, no flow control.
package mont_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLR,
        S_ADD_B,
        S_ADD_M,
        S_COLL,
        S_SUB,
        S_DONE
    } state_t;

    localparam logic [1:0] OP_ZERO = 2'b00;
    localparam logic [1:0] OP_B    = 2'b01;
    localparam logic [1:0] OP_M    = 2'b10;
    localparam logic [1:0] OP_NEGM = 2'b11;

    localparam logic [3:0] CHUNK_IDLE = 4'd8;
    localparam logic [3:0] CHUNK_LAST = 4'd4;

endpackage

// File: rtl/mont_seq_if.sv
// Command/status and datapath-strobe bundle between the sequencer and its surroundings.
// master = sequencer side; slave = command logic plus datapath side.
interface mont_seq_if;

    logic       start;
    logic       x_bit;
    logic       cZero;
    logic       carry;
    logic       x_next;
    logic [1:0] op_sel;
    logic       dp_resetn;
    logic       enableC;
    logic       shift;
    logic       subtract;
    logic [3:0] showFluffyPonies;
    logic       busy;
    logic       done;
    logic       err;

    modport master (
        input  start, x_bit, cZero, carry,
        output x_next, op_sel, dp_resetn, enableC, shift, subtract,
               showFluffyPonies, busy, done, err
    );

    modport slave (
        output start, x_bit, cZero, carry,
        input  x_next, op_sel, dp_resetn, enableC, shift, subtract,
               showFluffyPonies, busy, done, err
    );

endinterface

// File: rtl/chunk_cnt.sv
// 0..4 wrapping chunk select with load-to-idle (8) and load-to-zero; registered output.
// One step per cycle when step_i is high; idle load has priority over every other request.
module chunk_cnt
    import mont_pkg::*;
(
    input  logic       clk,
    input  logic       resetn,
    input  logic       load_idle_i,
    input  logic       load_zero_i,
    input  logic       step_i,
    output logic [3:0] chunk_o,
    output logic       last_o
);

    logic [3:0] chunk_q;
    logic [3:0] chunk_d;

    always_comb begin
        chunk_d = chunk_q;
        if (load_idle_i) begin
            chunk_d = CHUNK_IDLE;
        end else if (load_zero_i) begin
            chunk_d = 4'd0;
        end else if (step_i) begin
            chunk_d = (chunk_q == CHUNK_LAST) ? 4'd0 : chunk_q + 4'd1;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            chunk_q <= CHUNK_IDLE;
        end else begin
            chunk_q <= chunk_d;
        end
    end

    assign chunk_o = chunk_q;
    assign last_o  = (chunk_q == CHUNK_LAST);

endmodule

// File: rtl/mont_seq.sv
// Bit-serial Montgomery sequencer: accumulate/M-add/shift per bit, 5-chunk collapse, chunked subtract passes.
// start->done = 1 + 2*N_BITS + M-adds + 5 + 5*passes + 1 cycles; start is ignored while busy.
module mont_seq
    import mont_pkg::*;
#(
    parameter int N_BITS  = 512,
    parameter int MAX_SUB = 3
) (
    input  logic       clk,
    input  logic       resetn,
    mont_seq_if.master bus
);

    localparam int IW = (N_BITS > 1) ? $clog2(N_BITS) : 1;
    localparam int PW = $clog2(MAX_SUB + 1);
    localparam logic [IW-1:0] I_LAST = IW'(N_BITS - 1);
    localparam logic [PW-1:0] P_LAST = PW'(MAX_SUB - 1);

    state_t          state_q, state_d;
    logic [IW-1:0]   i_q, i_d;
    logic [PW-1:0]   p_q, p_d;
    logic            busy_q, subtract_q, done_q, err_q, dp_resetn_q;
    logic            err_d;

    logic            enable_c, shift_c, x_next_c;
    logic [1:0]      op_sel_c;
    logic            ld_idle, ld_zero, step;
    logic [3:0]      chunk;
    logic            chunk_last;

    chunk_cnt u_chunk (
        .clk         (clk),
        .resetn      (resetn),
        .load_idle_i (ld_idle),
        .load_zero_i (ld_zero),
        .step_i      (step),
        .chunk_o     (chunk),
        .last_o      (chunk_last)
    );

    always_comb begin
        state_d  = state_q;
        i_d      = i_q;
        p_d      = p_q;
        err_d    = 1'b0;
        enable_c = 1'b0;
        shift_c  = 1'b0;
        x_next_c = 1'b0;
        op_sel_c = OP_ZERO;
        ld_idle  = 1'b0;
        ld_zero  = 1'b0;
        step     = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    state_d = S_CLR;
                    i_d     = '0;
                    p_d     = '0;
                end
            end
            S_CLR: begin
                state_d = S_ADD_B;
            end
            S_ADD_B: begin
                // The bit source advances on the x_next edge, so the live bit is the right one here.
                enable_c = 1'b1;
                op_sel_c = bus.x_bit ? OP_B : OP_ZERO;
                state_d  = S_ADD_M;
            end
            S_ADD_M: begin
                if (bus.cZero) begin
                    enable_c = 1'b1;
                    op_sel_c = OP_M;
                end else begin
                    shift_c  = 1'b1;
                    x_next_c = 1'b1;
                    if (i_q == I_LAST) begin
                        state_d = S_COLL;
                        ld_zero = 1'b1;
                    end else begin
                        i_d     = i_q + IW'(1);
                        state_d = S_ADD_B;
                    end
                end
            end
            S_COLL: begin
                step = 1'b1;
                if (chunk_last) begin
                    state_d = S_SUB;
                end
            end
            S_SUB: begin
                op_sel_c = OP_NEGM;
                step     = 1'b1;
                if (chunk_last) begin
                    if (bus.carry) begin
                        state_d = S_DONE;
                        ld_idle = 1'b1;
                    end else begin
                        p_d = p_q + PW'(1);
                        if (p_q == P_LAST) begin
                            state_d = S_DONE;
                            ld_idle = 1'b1;
                            err_d   = 1'b1;
                        end
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                ld_idle = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= S_IDLE;
            i_q         <= '0;
            p_q         <= '0;
            busy_q      <= 1'b0;
            subtract_q  <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            dp_resetn_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            i_q         <= i_d;
            p_q         <= p_d;
            busy_q      <= (state_d != S_IDLE);
            subtract_q  <= (state_d == S_SUB);
            done_q      <= (state_d == S_DONE);
            err_q       <= err_d;
            dp_resetn_q <= (state_d != S_CLR);
        end
    end

    assign bus.x_next           = x_next_c;
    assign bus.op_sel           = op_sel_c;
    assign bus.enableC          = enable_c;
    assign bus.shift            = shift_c;
    assign bus.dp_resetn        = dp_resetn_q;
    assign bus.subtract         = subtract_q;
    assign bus.showFluffyPonies = chunk;
    assign bus.busy             = busy_q;
    assign bus.done             = done_q;
    assign bus.err              = err_q;

endmodule

// File: tb/tb_mont_seq.sv
// Randomised bench for mont_seq: a per-cycle expected trace is built from the operation rules and compared cycle by cycle.
module tb_mont_seq;
    import mont_pkg::*;

    localparam int   NB = 4;
    localparam int   MS = 3;
    localparam logic L  = 1'b0;
    localparam logic H  = 1'b1;

    logic clk    = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    mont_seq_if bus ();
    mont_seq_if bus1 ();

    mont_seq #(.N_BITS(NB), .MAX_SUB(MS)) dut  (.clk(clk), .resetn(resetn), .bus(bus.master));
    mont_seq #(.N_BITS(1),  .MAX_SUB(MS)) dut1 (.clk(clk), .resetn(resetn), .bus(bus1.master));

    int n_tests   = 0;
    int n_fail    = 0;
    int bad_chunk = 0;

    // {chunk, op_sel, enableC, shift, x_next, subtract, busy, done, err, dp_resetn}
    logic [13:0] obs_w;
    assign obs_w = {bus.showFluffyPonies, bus.op_sel, bus.enableC, bus.shift, bus.x_next,
                    bus.subtract, bus.busy, bus.done, bus.err, bus.dp_resetn};

    typedef struct packed {
        logic [13:0] o;
        logic        xb;
        logic        cz;
        logic        cy;
    } cyc_t;

    cyc_t exp_q[$];

    function automatic logic [13:0] mk(input logic [3:0] ch, input logic [1:0] op, input logic en,
                                       input logic sh, input logic xn, input logic sub, input logic bsy,
                                       input logic dn, input logic er, input logic dpr);
        return {ch, op, en, sh, xn, sub, bsy, dn, er, dpr};
    endfunction

    function automatic void push(input logic [13:0] o, input logic xb, input logic cz, input logic cy);
        exp_q.push_back({o, xb, cz, cy});
    endfunction

    // Expected cycle trace from CLR through DONE. cpass = pass on which carry rises (0 = never).
    function automatic void build(input logic [NB-1:0] x, input logic [NB-1:0] madd, input int cpass);
        int npass;
        exp_q.delete();
        push(mk(CHUNK_IDLE, OP_ZERO, L, L, L, L, H, L, L, L), x[0], L, L);
        for (int b = 0; b < NB; b++) begin
            push(mk(CHUNK_IDLE, x[b] ? OP_B : OP_ZERO, H, L, L, L, H, L, L, H), x[b], L, L);
            if (madd[b]) push(mk(CHUNK_IDLE, OP_M, H, L, L, L, H, L, L, H), x[b], H, L);
            push(mk(CHUNK_IDLE, OP_ZERO, L, H, H, L, H, L, L, H), x[b], L, L);
        end
        for (int c = 0; c < 5; c++) push(mk(4'(c), OP_ZERO, L, L, L, L, H, L, L, H), L, L, L);
        npass = (cpass == 0) ? MS : cpass;
        for (int p = 1; p <= npass; p++)
            for (int c = 0; c < 5; c++)
                push(mk(4'(c), OP_NEGM, L, L, L, H, H, L, L, H), L, L, (c == 4 && p == cpass));
        push(mk(CHUNK_IDLE, OP_ZERO, L, L, L, L, H, H, (cpass == 0), H), L, L, L);
    endfunction

    // Entered in an IDLE cycle at posedge+2; leaves in the following IDLE cycle at posedge+2.
    task automatic run_op(input logic [NB-1:0] x, input logic [NB-1:0] madd, input int cpass,
                          input logic hold, input logic chain, input string tag);
        int done_at = 0;
        int xn      = 0;
        int exp_lat;
        build(x, madd, cpass);
        bus.start = 1'b1;
        foreach (exp_q[k]) begin
            @(posedge clk); #1;
            bus.start = hold;
            bus.x_bit = exp_q[k].xb;
            bus.cZero = exp_q[k].cz;
            bus.carry = exp_q[k].cy;
            #1;
            n_tests++;
            if (obs_w !== exp_q[k].o) begin
                n_fail++;
                $display("FAIL %s cyc%0d: got %h want %h", tag, k + 1, obs_w, exp_q[k].o);
            end
            if (bus.done === 1'b1 && done_at == 0) done_at = k + 1;
            if (bus.x_next === 1'b1) xn++;
            if (bus.showFluffyPonies inside {[4'd5:4'd7], [4'd9:4'd15]}) bad_chunk++;
        end
        @(posedge clk); #1;
        bus.start = chain;
        bus.cZero = 1'b0;
        bus.carry = 1'b0;
        #1;
        n_tests++;
        if (obs_w !== mk(CHUNK_IDLE, OP_ZERO, L, L, L, L, L, L, L, H)) begin
            n_fail++;
            $display("FAIL %s idle_after: got %h want idle", tag, obs_w);
        end
        exp_lat = 1 + 2 * NB + $countones(madd) + 5 + 5 * ((cpass == 0) ? MS : cpass) + 1;
        n_tests++;
        if (done_at != exp_lat) begin
            n_fail++;
            $display("FAIL %s latency: got %0d want %0d", tag, done_at, exp_lat);
        end
        n_tests++;
        if (xn != NB) begin
            n_fail++;
            $display("FAIL %s x_next_count: got %0d want %0d", tag, xn, NB);
        end
    endtask

    task automatic test_reset;
        #12;
        n_tests++;
        if (obs_w !== mk(CHUNK_IDLE, OP_ZERO, L, L, L, L, L, L, L, L)) begin
            n_fail++;
            $display("FAIL reset_values: got %h want %h", obs_w, mk(CHUNK_IDLE, OP_ZERO, L, L, L, L, L, L, L, L));
        end
        @(negedge clk) resetn = 1'b1;
        @(posedge clk); #1;
        n_tests++;
        if (obs_w !== mk(CHUNK_IDLE, OP_ZERO, L, L, L, L, L, L, L, H)) begin
            n_fail++;
            $display("FAIL reset_release: got %h want dp_resetn high idle", obs_w);
        end
        #1;
    endtask

    task automatic test_basic;
        run_op(4'b1011, 4'b0000, 1, L, L, "basic");
    endtask

    task automatic test_madd;
        run_op(4'b1011, 4'b1111, 1, L, L, "madd_every_bit");
    endtask

    task automatic test_max_sub;
        run_op(4'b0110, 4'b0000, 0, L, L, "max_sub_err");
    endtask

    task automatic test_random;
        logic [NB-1:0] xr, mr;
        int cp;
        for (int n = 0; n < 6; n++) begin
            xr = NB'($urandom);
            mr = NB'($urandom);
            cp = int'($urandom_range(0, 3));
            run_op(xr, mr, cp, L, L, $sformatf("rand%0d", n));
        end
    endtask

    task automatic test_back_to_back;
        run_op(4'b1001, 4'b0100, 2, H, H, "b2b_first");
        run_op(4'b0111, 4'b0010, 1, H, L, "b2b_second");
    endtask

    task automatic test_reset_mid;
        int  k   = 0;
        bit  hit = 0;
        bus.start = 1'b1;
        bus.x_bit = 1'b1;
        bus.cZero = 1'b0;
        bus.carry = 1'b0;
        while (k < 60 && !hit) begin
            @(posedge clk); #1;
            bus.start = 1'b0;
            k++;
            if (bus.showFluffyPonies == 4'd2 && bus.subtract === 1'b0 && bus.busy === 1'b1) hit = 1;
        end
        n_tests++;
        if (!hit) begin
            n_fail++;
            $display("FAIL reset_mid_reach_coll2: got no chunk 2 in %0d cycles want reached", k);
        end
        #2 resetn = 1'b0;
        #1;
        n_tests++;
        if (obs_w !== mk(CHUNK_IDLE, OP_ZERO, L, L, L, L, L, L, L, L)) begin
            n_fail++;
            $display("FAIL reset_mid_async: got %h want reset values", obs_w);
        end
        @(posedge clk); #1;
        n_tests++;
        if (obs_w !== mk(CHUNK_IDLE, OP_ZERO, L, L, L, L, L, L, L, L)) begin
            n_fail++;
            $display("FAIL reset_mid_held: got %h want reset values", obs_w);
        end
        @(negedge clk) resetn = 1'b1;
        @(posedge clk); #2;
        run_op(4'b1101, 4'b1010, 2, L, L, "after_reset");
    endtask

    task automatic test_min_nbits;
        int k = 0;
        bus1.start = 1'b1;
        bus1.x_bit = 1'b1;
        bus1.cZero = 1'b0;
        bus1.carry = 1'b1;
        while (k < 40 && bus1.done !== 1'b1) begin
            @(posedge clk); #1;
            bus1.start = 1'b0;
            k++;
        end
        n_tests++;
        if (k != 14) begin
            n_fail++;
            $display("FAIL min_latency_nbits1: got %0d want 14", k);
        end
        n_tests++;
        if (bus1.err !== 1'b0) begin
            n_fail++;
            $display("FAIL min_err_nbits1: got %b want 0", bus1.err);
        end
        #1;
    endtask

    task automatic test_chunk_range;
        n_tests++;
        if (bad_chunk != 0) begin
            n_fail++;
            $display("FAIL chunk_range: got %0d illegal chunk cycles want 0", bad_chunk);
        end
    endtask

    initial begin
        bus.start  = 1'b0;
        bus.x_bit  = 1'b0;
        bus.cZero  = 1'b0;
        bus.carry  = 1'b0;
        bus1.start = 1'b0;
        bus1.x_bit = 1'b0;
        bus1.cZero = 1'b0;
        bus1.carry = 1'b0;
        test_reset();
        test_basic();
        test_madd();
        test_max_sub();
        test_random();
        test_back_to_back();
        test_reset_mid();
        test_min_nbits();
        test_chunk_range();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
